// File: rtl/led_pkg.sv
// Shared widths and FSM state type for the LED panel SPI row transmitter.
package led_pkg;

  localparam int ROW_BITS  = 288;
  localparam int ADDR_W    = 4;
  localparam int TX_BITS   = ROW_BITS + ADDR_W;
  localparam int BIT_CNT_W = 9;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} spi_tx_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI clock: strobes at the end of each sclk half-period while run is high.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic rise_stb,
  output logic fall_stb,
  output logic fall_next
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise_stb = run && !phase && (cnt == LAST);
  assign fall_stb = run &&  phase && (cnt == LAST);

  // fall_next flags the cycle just before fall_stb so a registered output can line up with it.
  generate
    if (CLK_DIV == 1) begin : g_div1
      assign fall_next = rise_stb;
    end else begin : g_divn
      localparam logic [CW-1:0] PRE = CW'(CLK_DIV - 2);
      assign fall_next = run && phase && (cnt == PRE);
    end
  endgenerate

endmodule

// File: rtl/led_spi_tx.sv
// SPI row transmitter for the LED panel link: one {addr, data} word per handshake, MSB first.
// Optional chip select output enabled by defining LED_SPI_CS_EN.
module led_spi_tx
  import led_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [ROW_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                sclk,
  output logic                mosi,
  output logic                busy,
  output logic                done
`ifdef LED_SPI_CS_EN
  ,
  output logic                cs_n
`endif
);

`ifdef LED_SPI_CS_EN
  localparam int GAP_EFF = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
`else
  localparam int GAP_EFF = GAP_CYCLES;
`endif
  localparam int GW = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_EFF - 1);
  localparam logic [GW-1:0]        GAP_PRE  = GW'(GAP_EFF - 2);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(TX_BITS - 1);

  spi_tx_state_t        state;
  logic [TX_BITS-2:0]   rest;     // bits still to send after the one on mosi
  logic [BIT_CNT_W-1:0] bitcnt;
  logic [GW-1:0]        gap_cnt;
  logic                 run, rise_stb, fall_stb, fall_next, last_bit;

  assign run      = (state == SHIFT_LO) || (state == SHIFT_HI);
  assign last_bit = (bitcnt == LAST_BIT);
  assign in_ready = (state == IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .fall_next (fall_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is reset too so an aborted word leaves no stale bits behind.
      state   <= IDLE;
      rest    <= '0;
      bitcnt  <= '0;
      gap_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (GAP_EFF == 0 && fall_next && last_bit) done <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          mosi   <= in_addr[ADDR_W-1];
          rest   <= {in_addr[ADDR_W-2:0], in_data};
          bitcnt <= '0;
          busy   <= 1'b1;
          state  <= SHIFT_LO;
        end
        SHIFT_LO: if (rise_stb) begin
          sclk  <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: if (fall_stb) begin
          sclk <= 1'b0;
          if (last_bit) begin
            mosi    <= 1'b0;
            gap_cnt <= '0;
            if (GAP_EFF == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              if (GAP_EFF == 1) done <= 1'b1;
              state <= GAP;
            end
          end else begin
            mosi   <= rest[TX_BITS-2];
            rest   <= {rest[TX_BITS-3:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
            state  <= SHIFT_LO;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (GAP_EFF >= 2 && gap_cnt == GAP_PRE) done <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_SPI_CS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   cs_n <= 1'b1;
    else if (state == IDLE && in_valid)           cs_n <= 1'b0;
    else if (state == SHIFT_HI && fall_stb && last_bit) cs_n <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_led_spi_tx.sv
// Bench for led_spi_tx: a default instance (CLK_DIV=4, GAP=8) and an edge instance (CLK_DIV=1, GAP=0)
// checked against a bit-level receiver model and cycle-count expectations.
module tb_led_spi_tx;

  localparam int NB = 292;
`ifdef LED_SPI_CS_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid [2];
  logic [3:0]   addr  [2];
  logic [287:0] data  [2];
  logic         ready [2], sclk [2], mosi [2], busy [2], done [2];
`ifdef LED_SPI_CS_EN
  logic         cs_n  [2];
`endif

  int cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_spi_tx #(.CLK_DIV(4), .GAP_CYCLES(8)) u_a (
    .clk(clk), .reset(rst_n), .in_valid(valid[0]), .in_addr(addr[0]), .in_data(data[0]),
    .in_ready(ready[0]), .sclk(sclk[0]), .mosi(mosi[0]), .busy(busy[0]), .done(done[0])
`ifdef LED_SPI_CS_EN
    , .cs_n(cs_n[0])
`endif
  );

  led_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(rst_n), .in_valid(valid[1]), .in_addr(addr[1]), .in_data(data[1]),
    .in_ready(ready[1]), .sclk(sclk[1]), .mosi(mosi[1]), .busy(busy[1]), .done(done[1])
`ifdef LED_SPI_CS_EN
    , .cs_n(cs_n[1])
`endif
  );

  // Receiver model: shift mosi in on every sampled sclk rise, as the panel receiver does.
  logic [NB-1:0] rx_sh [2];
  logic          prev_sclk [2] = '{1'b0, 1'b0};
  logic          prev_mosi [2] = '{1'b0, 1'b0};
  int            edges [2], low_run [2], last_low [2], glitches [2], cs_low [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (sclk[g] && !prev_sclk[g]) begin
        rx_sh[g]    <= {rx_sh[g][NB-2:0], mosi[g]};
        edges[g]    <= edges[g] + 1;
        last_low[g] <= low_run[g];
      end
      low_run[g] <= sclk[g] ? 0 : low_run[g] + 1;
      if (sclk[g] && prev_sclk[g] && mosi[g] !== prev_mosi[g]) glitches[g] <= glitches[g] + 1;
`ifdef LED_SPI_CS_EN
      if (!cs_n[g]) cs_low[g] <= cs_low[g] + 1;
`endif
      prev_sclk[g] <= sclk[g];
      prev_mosi[g] <= mosi[g];
    end
  end

  function automatic int div_of(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int g);
    int gp = (g == 0) ? 8 : 0;
    return (CS != 0 && gp == 0) ? 1 : gp;
  endfunction

  function automatic int turn_of(input int g);
    return 1 + 2 * div_of(g) * NB + gap_of(g);
  endfunction

  function automatic logic [287:0] rnd288();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [3:0] a, input logic [287:0] d, output int acc);
    for (int i = 0; i < 3000 && !ready[g]; i++) tick();
    check("ready_before_send", 32'(ready[g]), 32'd1);
    addr[g]  = a;
    data[g]  = d;
    valid[g] = 1'b1;
    acc      = cyc;
    tick();
  endtask

  task automatic wait_done(input int g, output int dcyc);
    for (int i = 0; i < 3000 && !done[g]; i++) tick();
    check("done_seen", 32'(done[g]), 32'd1);
    dcyc = cyc;
  endtask

  // One complete word: timing, edge count, received bits and ready turnaround.
  task automatic xfer(input int g, input logic [3:0] a, input logic [287:0] d);
    int acc, dcyc, e0, c0;
    e0 = edges[g];
    c0 = cs_low[g];
    send(g, a, d, acc);
    valid[g] = 1'b0;
    check("busy_after_accept", 32'(busy[g]), 32'd1);
    wait_done(g, dcyc);
    check("done_latency", 32'(dcyc - acc), 32'(turn_of(g) - 1));
    check("edge_count", 32'(edges[g] - e0), 32'(NB));
    check_word("rx_word", rx_sh[g], {a, d});
    tick();
    check("ready_turnaround", 32'(ready[g]), 32'd1);
    check("ready_latency", 32'(cyc - acc), 32'(turn_of(g)));
    check("done_one_cycle", 32'(done[g]), 32'd0);
`ifdef LED_SPI_CS_EN
    check("cs_low_cycles", 32'(cs_low[g] - c0), 32'(2 * div_of(g) * NB));
`endif
  endtask

  initial begin
    int acc, dcyc, e0;
    logic [3:0]   a1, a2;
    logic [287:0] w1, w2;
    logic [NB-1:0] snap;

    for (int g = 0; g < 2; g++) begin
      valid[g] = 1'b0;
      addr[g]  = '0;
      data[g]  = '0;
    end
    repeat (3) tick();
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_sclk",  32'(sclk[0]),  32'd0);
    check("rst_mosi",  32'(mosi[0]),  32'd0);
    check("rst_busy",  32'(busy[0]),  32'd0);
    check("rst_done",  32'(done[0]),  32'd0);
`ifdef LED_SPI_CS_EN
    check("rst_cs_n",  32'(cs_n[0]),  32'd1);
`endif
    rst_n = 1'b1;
    tick();

    // Reset mid-word aborts immediately and asynchronously
    e0 = edges[0];
    send(0, 4'h5, rnd288(), acc);
    valid[0] = 1'b0;
    for (int i = 0; i < 3000 && (edges[0] - e0) < 100; i++) tick();
    check("abort_reached_bit100", 32'(edges[0] - e0), 32'd100);
    #2 rst_n = 1'b0;
    #1;
    check("async_sclk",  32'(sclk[0]),  32'd0);
    check("async_mosi",  32'(mosi[0]),  32'd0);
    check("async_busy",  32'(busy[0]),  32'd0);
    check("async_ready", 32'(ready[0]), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    xfer(0, 4'(($urandom() % 16)), rnd288());

    // Single word with known pattern: 1010 address, one trailing data bit
    xfer(0, 4'hA, 288'h1);

    // Back-to-back with in_valid held; data changed while busy is ignored
    a1 = 4'($urandom());
    a2 = 4'($urandom());
    w1 = rnd288();
    w2 = rnd288();
    e0 = edges[0];
    send(0, a1, w1, acc);
    addr[0] = a2;
    data[0] = w2;
    wait_done(0, dcyc);
    check("b2b_done_latency", 32'(dcyc - acc), 32'(turn_of(0) - 1));
    snap = rx_sh[0];
    check_word("b2b_word1", snap, {a1, w1});
    tick();
    check("b2b_ready_first_idle", 32'(ready[0]), 32'd1);
    tick();
    check("b2b_accepted_busy", 32'(busy[0]), 32'd1);
    check("b2b_accepted_ready", 32'(ready[0]), 32'd0);
    valid[0] = 1'b0;
    for (int i = 0; i < 3000 && (edges[0] - e0) < NB + 1; i++) tick();
    check("b2b_low_between", 32'(last_low[0]), 32'(gap_of(0) + 1 + div_of(0)));
    wait_done(0, dcyc);
    check("b2b_done2_latency", 32'(dcyc - acc), 32'(2 * turn_of(0) - 1));
    check_word("b2b_word2", rx_sh[0], {a2, w2});
    tick();

    // in_valid pulse with new data during SHIFT is not captured
    a1 = 4'($urandom());
    w1 = rnd288();
    send(0, a1, w1, acc);
    valid[0] = 1'b0;
    repeat (50 + $urandom_range(0, 400)) tick();
    addr[0]  = ~a1;
    data[0]  = rnd288();
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    check("pulse_busy", 32'(busy[0]), 32'd1);
    wait_done(0, dcyc);
    check("pulse_done_latency", 32'(dcyc - acc), 32'(turn_of(0) - 1));
    check_word("pulse_word", rx_sh[0], {a1, w1});
    repeat (4) tick();
    check("pulse_no_capture", 32'(busy[0]), 32'd0);

    // Edge parameters: CLK_DIV=1, GAP=0
    xfer(1, 4'($urandom()), rnd288());

    // Rows 0..15 with random data through the receiver model
    for (int r = 0; r < 16; r++) xfer(1, 4'(r), rnd288());

    check("mosi_stable_hi_a", 32'(glitches[0]), 32'd0);
    check("mosi_stable_hi_b", 32'(glitches[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
